// File: rtl/ysyx_22050019_axi_rd_arbiter.sv
// Shares one AXI read port (AR/R) between the IFU (master 0) and the LSU (master 1), one read at a time.
// Define YSYX_22050019_ARB_RR_EN for round-robin arbitration; the default is fixed LSU-over-IFU priority.
module ysyx_22050019_axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_ar_valid,
  output logic              ifu_ar_ready,
  input  logic [ADDR_W-1:0] ifu_araddr,
  output logic              ifu_r_valid,
  input  logic              ifu_r_ready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  input  logic              lsu_ar_valid,
  output logic              lsu_ar_ready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  output logic              lsu_r_valid,
  input  logic              lsu_r_ready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              mem_ar_valid,
  input  logic              mem_ar_ready,
  output logic [ADDR_W-1:0] mem_araddr,
  input  logic              mem_r_valid,
  output logic              mem_r_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR0,
    S_R0,
    S_AR1,
    S_R1
  } state_t;

  state_t state;
  logic   ar_hs;
  logic   r_hs;
  logic   pick_lsu;

  assign ar_hs = mem_ar_valid && mem_ar_ready;
  assign r_hs  = mem_r_valid && mem_r_ready;

`ifdef YSYX_22050019_ARB_RR_EN
  logic last_grant;  // 0 = IFU served last, 1 = LSU served last

  // On a tie the master that was not served last wins.
  assign pick_lsu = lsu_ar_valid && (!ifu_ar_valid || !last_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b0;
    end else if (r_hs) begin
      last_grant <= (state == S_R1);
    end
  end
`else
  assign pick_lsu = lsu_ar_valid;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (ifu_ar_valid || lsu_ar_valid) begin
            state <= pick_lsu ? S_AR1 : S_AR0;
          end
        end
        S_AR0: if (ar_hs) state <= S_R0;
        S_AR1: if (ar_hs) state <= S_R1;
        S_R0, S_R1: if (r_hs) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // The grant only steers the channels; the non-granted master sees all zeros.
  always_comb begin
    // NOTE: every output is defaulted before the case so no path can infer a latch.
    ifu_ar_ready = 1'b0;
    ifu_r_valid  = 1'b0;
    ifu_rdata    = '0;
    ifu_rresp    = '0;
    lsu_ar_ready = 1'b0;
    lsu_r_valid  = 1'b0;
    lsu_rdata    = '0;
    lsu_rresp    = '0;
    mem_ar_valid = 1'b0;
    mem_araddr   = '0;
    mem_r_ready  = 1'b0;
    case (state)
      S_AR0: begin
        mem_ar_valid = ifu_ar_valid;
        mem_araddr   = ifu_araddr;
        ifu_ar_ready = mem_ar_ready;
      end
      S_AR1: begin
        mem_ar_valid = lsu_ar_valid;
        mem_araddr   = lsu_araddr;
        lsu_ar_ready = mem_ar_ready;
      end
      S_R0: begin
        ifu_r_valid = mem_r_valid;
        ifu_rdata   = mem_rdata;
        ifu_rresp   = mem_rresp;
        mem_r_ready = ifu_r_ready;
      end
      S_R1: begin
        lsu_r_valid = mem_r_valid;
        lsu_rdata   = mem_rdata;
        lsu_rresp   = mem_rresp;
        mem_r_ready = lsu_r_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/ysyx_22050019_axi_rd_arbiter.md
Name: ysyx_22050019_axi_rd_arbiter

Overview:
- Shares the single memory AXI read port (AR/R) between the instruction fetch unit (IFU, master 0) and the load/store unit (LSU, master 1).
- One outstanding read at a time. The grant is held from AR handshake through R handshake.
- The write channels (AW/W/B) do not pass through this block; the LSU drives them to memory directly.

Parameters:
ADDR_W, 32, address width of all araddr ports
DATA_W, 64, data width of all rdata ports

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
ifu_ar_valid  in  1  IFU read-address valid
ifu_ar_ready  out  1  IFU read-address ready
ifu_araddr  in  ADDR_W  IFU read address
ifu_r_valid  out  1  IFU read-data valid
ifu_r_ready  in  1  IFU read-data ready
ifu_rdata  out  DATA_W  IFU read data
ifu_rresp  out  2  IFU read response
lsu_ar_valid / lsu_ar_ready / lsu_araddr / lsu_r_valid / lsu_r_ready / lsu_rdata / lsu_rresp  same directions/widths as IFU set  LSU read port
mem_ar_valid  out  1  memory read-address valid
mem_ar_ready  in  1  memory read-address ready
mem_araddr  out  ADDR_W  memory read address
mem_r_valid  in  1  memory read-data valid
mem_r_ready  out  1  memory read-data ready
mem_rdata  in  DATA_W  memory read data
mem_rresp  in  2  memory read response

Behaviour:
- Clock `clk`, reset `rst`: asynchronous, active-high.
- **Reset:**
  - State goes to S_IDLE immediately, with no clock edge needed.
  - All outputs are 0: every ar_ready, r_valid, rdata, rresp, mem_ar_valid, mem_r_ready, mem_araddr.
  - Reset mid-transaction abandons the transaction. Memory is reset in the same domain, so no stray beat is expected.
- **States:** S_IDLE, S_AR0, S_R0, S_AR1, S_R1. The state is registered; outputs are combinational from state and inputs.
- **S_IDLE:**
  - No output is asserted; mem_r_ready=0.
  - If any ar_valid is high, choose the winner and go to S_AR0 (IFU) or S_AR1 (LSU) next cycle.
  - Arbitration latency is 1 cycle: a request seen at edge t gives mem_ar_valid high in cycle t+1.
- **Arbitration (default):** fixed priority, LSU over IFU.
- **S_ARn:**
  - mem_ar_valid = granted ar_valid; mem_araddr = granted araddr.
  - granted ar_ready = mem_ar_ready; the other master's ar_ready = 0.
  - On mem_ar_valid && mem_ar_ready, go to S_Rn.
  - If the granted master drops ar_valid (protocol violation), stay in S_ARn.
- **S_Rn:**
  - granted r_valid = mem_r_valid; granted rdata/rresp = mem_rdata/mem_rresp.
  - mem_r_ready = granted r_ready.
  - On mem_r_valid && mem_r_ready, go to S_IDLE.
  - mem_ar_valid = 0.
- **Non-granted master:** r_valid=0, rdata=0, rresp=0, ar_ready=0 in every state.
- **Request arriving while busy:** it waits. It is arbitrated in the S_IDLE cycle that follows the R handshake.
- **Throughput:** minimum 3 cycles per transaction (IDLE, AR, R) with zero-wait memory.
- **Protocol:** masters hold ar_valid/araddr stable until ar_ready. The arbiter never drops mem_ar_valid before handshake while the master holds valid.
- **Width:** rresp is passed through unmodified. No data width or alignment conversion is done.

Optional Feature:
- Macro YSYX_22050019_ARB_RR_EN.
- **Defined:** round-robin arbitration.
  - A 1-bit last_grant register (reset 0 = IFU) updates to the served master on each R handshake.
  - On simultaneous requests in S_IDLE, the master ≠ last_grant wins.
  - A single request wins regardless of last_grant.
- **Undefined:** fixed LSU priority; no last_grant register exists.

Test Plan:
- **IFU alone:** ifu_araddr=0x8000_0000, mem_ar_ready=1, mem_r_valid with rdata=0x1122334455667788 two cycles later, ifu_r_ready=1.
  - mem_ar_valid rises the cycle after request; ifu_ar_ready pulses 1 cycle.
  - ifu_rdata=0x1122334455667788; lsu_r_valid stays 0; returns to S_IDLE.
- **Tie in S_IDLE:** IFU 0x8000_0004 and LSU 0x8000_1000 both valid.
  - mem_araddr=0x8000_1000 first; IFU served after the LSU R handshake.
  - With RR_EN, a second repeated tie grants IFU first.
- **Busy:** LSU request raised while in S_R0 → lsu_ar_ready=0 until the IFU R handshake completes; LSU is granted in the next S_IDLE cycle.
- **Backpressure:**
  - mem_ar_ready low for 3 cycles → mem_ar_valid=1 and mem_araddr stable throughout.
  - Then mem_r_valid=1 with lsu_r_ready=0 for 2 cycles → mem_r_ready=0, lsu_r_valid=1, state held in S_R1.
- **Async reset:** rst asserted between clock edges in S_R1 → lsu_r_valid and mem_r_ready drop to 0 immediately; after deassert, state is S_IDLE and a new IFU request is served normally.
- **Error response:** mem_rresp=2'b10 on an LSU read → lsu_rresp=2'b10 in the same cycle as lsu_r_valid; ifu_rresp=0.
